uart_rx_fifo: RTL



---
 rtl/uart_rx_fifo.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver: 2-flop input sync, mid-bit sampling, stop-bit check and a receive FIFO.
// Define PARITY_CHECK_EN to add an even-parity bit between the data bits and the stop bit.
module uart_rx_fifo #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned BIT_PERIOD = 10,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            n_rst,
  input  logic                            serial_in,
  input  logic                            data_read,
  output logic [DATA_BITS-1:0]            rx_data,
  output logic                            data_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            framing_error,
  output logic                            overrun_error,
  output logic                            parity_error
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned TmrW = $clog2(BIT_PERIOD);
  localparam int unsigned BitW = $clog2(DATA_BITS);

  localparam logic [TmrW-1:0] HalfLoad = TmrW'(BIT_PERIOD / 2 - 1);
  localparam logic [TmrW-1:0] FullLoad = TmrW'(BIT_PERIOD - 1);
  localparam logic [BitW-1:0] LastBit  = BitW'(DATA_BITS - 1);
  localparam logic [CntW-1:0] FullCnt  = CntW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef PARITY_CHECK_EN
    StParity,
`endif
    StStop
  } state_e;

  // Input synchroniser plus a delayed copy for falling-edge detection
  logic sync1_q, sync2_q, line_prev_q;
  logic line, start_edge;

  assign line       = sync2_q;
  assign start_edge = line_prev_q & ~sync2_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      line_prev_q <= 1'b1;
    end else begin
      sync1_q     <= serial_in;
      sync2_q     <= sync1_q;
      line_prev_q <= sync2_q;
    end
  end

  state_e                 state_q, state_d;
  logic [TmrW-1:0]        timer_q, timer_d;
  logic [BitW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   framing_q, framing_d;
  logic                   push;
  logic                   tick;

  assign tick = (timer_q == '0);

`ifdef PARITY_CHECK_EN
  logic parity_bit_q, parity_bit_d;
  logic parity_err_q, parity_err_d;
  logic parity_bad;

  assign parity_bad   = ^{shift_q, parity_bit_q};
  assign parity_error = parity_err_q;
`else
  assign parity_error = 1'b0;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= StIdle;
      timer_q      <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      framing_q    <= 1'b0;
`ifdef PARITY_CHECK_EN
      parity_bit_q <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      framing_q    <= framing_d;
`ifdef PARITY_CHECK_EN
      parity_bit_q <= parity_bit_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    timer_d      = (state_q != StIdle && !tick) ? timer_q - TmrW'(1) : timer_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    framing_d    = framing_q;
    push         = 1'b0;
`ifdef PARITY_CHECK_EN
    parity_bit_d = parity_bit_q;
    parity_err_d = parity_err_q;
`endif
    case (state_q)
      StIdle: begin
        if (start_edge) begin
          state_d   = StStart;
          timer_d   = HalfLoad;
          framing_d = 1'b0;
`ifdef PARITY_CHECK_EN
          parity_err_d = 1'b0;
`endif
        end
      end
      StStart: begin
        if (tick) begin
          if (line) begin
            state_d = StIdle;
          end else begin
            state_d   = StData;
            timer_d   = FullLoad;
            bit_cnt_d = '0;
          end
        end
      end
      StData: begin
        if (tick) begin
          shift_d = {line, shift_q[DATA_BITS-1:1]};
          timer_d = FullLoad;
          if (bit_cnt_q == LastBit) begin
`ifdef PARITY_CHECK_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + BitW'(1);
          end
        end
      end
`ifdef PARITY_CHECK_EN
      StParity: begin
        if (tick) begin
          parity_bit_d = line;
          timer_d      = FullLoad;
          state_d      = StStop;
        end
      end
`endif
      StStop: begin
        if (tick) begin
          state_d = StIdle;
          if (!line) framing_d = 1'b1;
`ifdef PARITY_CHECK_EN
          if (parity_bad) parity_err_d = 1'b1;
          push = line & ~parity_bad;
`else
          push = line;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign framing_error = framing_q;

  // Receive FIFO; a full FIFO still accepts a push when the head is popped the same cycle
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]      count_q;
  logic                 overrun_q;
  logic                 pop, full, wr_en;

  assign full  = (count_q == FullCnt);
  assign pop   = data_read & (count_q != '0);
  assign wr_en = push & (~full | pop);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (wr_en && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (pop && !wr_en) begin
        count_q <= count_q - CntW'(1);
      end
      if (pop) begin
        overrun_q <= 1'b0;
      end else if (push && full) begin
        overrun_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= shift_q;
  end

  assign data_ready    = (count_q != '0);
  assign fifo_count    = count_q;
  assign overrun_error = overrun_q;
  assign rx_data       = data_ready ? mem_q[rd_ptr_q] : '0;

endmodule
